decode_sb: RTL

// Parametrised decode stage with valid/ready handshakes and a register scoreboard.

---
 rtl/decode_sb_pkg.sv | 43 ++++
 rtl/decode_sb_scoreboard.sv | 50 +++++
 rtl/decode_sb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/decode_sb_pkg.sv
// Shared types and constants for the decode stage: opcode map, ALU select codes
// and the instruction field layout.
package decode_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_IMM_W      = 11;
  localparam int INSTR_W        = 32;

  localparam int FLD_OP_W    = 6;
  localparam int FLD_RS1_LSB = 6;
  localparam int FLD_RS2_LSB = 11;
  localparam int FLD_RD_LSB  = 16;
  localparam int FLD_IMM_LSB = 21;

  typedef enum logic [FLD_OP_W-1:0] {
    OP_NOOP = 6'h00,
    OP_ADD  = 6'h01,
    OP_OR   = 6'h02,
    OP_AND  = 6'h03,
    OP_XOR  = 6'h04,
    OP_MULT = 6'h05,
    OP_ADDI = 6'h06
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_MULT = 4'b0110,
    ALU_ADDI = 4'b0111
  } alu_sel_e;

  typedef struct packed {
    alu_sel_e alu;
    logic     use_imm;
    logic     writes_rd;
    logic     illegal;
  } dec_ctl_t;

endpackage

// File: rtl/decode_sb_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set when a writer
// issues and cleared on write-back, with a write-back bypass on the busy queries.
module decode_sb_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_addr,
  input  logic [REG_AW-1:0] i_qa_addr,
  input  logic [REG_AW-1:0] i_qb_addr,
  output logic              o_busy_a,
  output logic              o_busy_b
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_next;
  logic            w_clr_hit_a;
  logic            w_clr_hit_b;

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    // NOTE: copy the current vector before the conditional updates so every bit is assigned on every path; no latch.
    w_sb_next = r_sb;
    if (i_clr_en) w_sb_next[i_clr_addr] = 1'b0;
    if (i_set_en) w_sb_next[i_set_addr] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: this vector is a handful of flops rather than a RAM, so it is reset like any other state.
    if (i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  assign w_clr_hit_a = i_clr_en && (i_clr_addr == i_qa_addr);
  assign w_clr_hit_b = i_clr_en && (i_clr_addr == i_qb_addr);

  assign o_busy_a = (i_qa_addr != '0) && r_sb[i_qa_addr] && !w_clr_hit_a;
  assign o_busy_b = (i_qb_addr != '0) && r_sb[i_qb_addr] && !w_clr_hit_b;

endmodule

// File: rtl/decode_sb.sv
// Decode stage: cracks the instruction word, holds RAW hazards against the scoreboard
// and the output register, and presents one decoded instruction to execute.
module decode_sb
  import decode_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int IMM_W      = DEF_IMM_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_pc_decode,
  input  logic [INSTR_W-1:0]    i_idata,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_pc_exe,
  output logic [REG_AW-1:0]     o_rega_addr,
  output logic [REG_AW-1:0]     o_regb_addr,
  output logic [REG_AW-1:0]     o_regd_addr,
  output logic [3:0]            o_alu_fns_sel,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic                  o_use_imm,
  output logic                  o_reg_write,
  output logic                  o_illegal_op,
  input  logic                  i_wb_valid,
  input  logic [REG_AW-1:0]     i_wb_addr
);

  logic [FLD_OP_W-1:0]   w_op;
  logic [REG_AW-1:0]     w_rs1;
  logic [REG_AW-1:0]     w_rs2;
  logic [REG_AW-1:0]     w_rd;
  logic [DATA_WIDTH-1:0] w_imm;
  dec_ctl_t              w_ctl;
  logic                  w_reg_write;

  logic                  w_sb_busy_a;
  logic                  w_sb_busy_b;
  logic                  w_rs1_busy;
  logic                  w_rs2_busy;
  logic                  w_issue;
  logic                  w_accept;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_pc_exe;
  logic [REG_AW-1:0]     r_rega;
  logic [REG_AW-1:0]     r_regb;
  logic [REG_AW-1:0]     r_regd;
  logic [3:0]            r_alu;
  logic [DATA_WIDTH-1:0] r_imm;
  logic                  r_use_imm;
  logic                  r_reg_write;
  logic                  r_illegal;

  assign w_op  = i_idata[FLD_OP_W-1:0];
  assign w_rs1 = i_idata[FLD_RS1_LSB +: REG_AW];
  assign w_rs2 = i_idata[FLD_RS2_LSB +: REG_AW];
  assign w_rd  = i_idata[FLD_RD_LSB +: REG_AW];
  assign w_imm = {{(DATA_WIDTH-IMM_W){i_idata[FLD_IMM_LSB+IMM_W-1]}},
                  i_idata[FLD_IMM_LSB +: IMM_W]};

  // Unknown opcodes decode as NOOP and are flagged; they never write rd.
  always_comb begin
    w_ctl = '{alu: ALU_NOP, use_imm: 1'b0, writes_rd: 1'b0, illegal: 1'b0};
    case (w_op)
      OP_NOOP: w_ctl.alu = ALU_NOP;
      OP_ADD:  w_ctl = '{alu: ALU_ADD,  use_imm: 1'b0, writes_rd: 1'b1, illegal: 1'b0};
      OP_OR:   w_ctl = '{alu: ALU_OR,   use_imm: 1'b0, writes_rd: 1'b1, illegal: 1'b0};
      OP_AND:  w_ctl = '{alu: ALU_AND,  use_imm: 1'b0, writes_rd: 1'b1, illegal: 1'b0};
      OP_XOR:  w_ctl = '{alu: ALU_XOR,  use_imm: 1'b0, writes_rd: 1'b1, illegal: 1'b0};
      OP_MULT: w_ctl = '{alu: ALU_MULT, use_imm: 1'b0, writes_rd: 1'b1, illegal: 1'b0};
      OP_ADDI: w_ctl = '{alu: ALU_ADDI, use_imm: 1'b1, writes_rd: 1'b1, illegal: 1'b0};
      default: w_ctl.illegal = 1'b1;
    endcase
  end

  assign w_reg_write = w_ctl.writes_rd && (w_rd != '0);

  decode_sb_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set_en   (w_issue && r_reg_write),
    .i_set_addr (r_regd),
    .i_clr_en   (i_wb_valid),
    .i_clr_addr (i_wb_addr),
    .i_qa_addr  (w_rs1),
    .i_qb_addr  (w_rs2),
    .o_busy_a   (w_sb_busy_a),
    .o_busy_b   (w_sb_busy_b)
  );

  // The writer still sitting in the output register has no scoreboard bit yet.
  assign w_rs1_busy = w_sb_busy_a ||
                      (r_out_valid && r_reg_write && (r_regd == w_rs1) && (w_rs1 != '0));
  assign w_rs2_busy = !w_ctl.use_imm &&
                      (w_sb_busy_b ||
                       (r_out_valid && r_reg_write && (r_regd == w_rs2) && (w_rs2 != '0)));

  assign w_issue    = r_out_valid && i_out_ready && !i_stall && !i_flush;
  assign o_in_ready = !i_stall && !i_flush && !w_rs1_busy && !w_rs2_busy &&
                      (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_pc_exe    <= '0;
      r_rega      <= '0;
      r_regb      <= '0;
      r_regd      <= '0;
      r_alu       <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (!i_stall) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_pc_exe    <= i_pc_decode;
        r_rega      <= w_rs1;
        r_regb      <= w_rs2;
        r_regd      <= w_rd;
        r_alu       <= w_ctl.alu;
        r_imm       <= w_imm;
        r_use_imm   <= w_ctl.use_imm;
        r_reg_write <= w_reg_write;
        r_illegal   <= w_ctl.illegal;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_pc_exe      = r_pc_exe;
  assign o_rega_addr   = r_rega;
  assign o_regb_addr   = r_regb;
  assign o_regd_addr   = r_regd;
  assign o_alu_fns_sel = r_alu;
  assign o_imm         = r_imm;
  assign o_use_imm     = r_use_imm;
  assign o_reg_write   = r_reg_write;
  assign o_illegal_op  = r_illegal;

endmodule
